if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_pkg.sv | 12 +
 rtl/if_fifo.sv | 51 +++++
 rtl/if_fetch_queue.sv | 119 +++++++++++
 tb/tb_if_fetch_queue.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue.
package if_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } if_state_e;

  localparam logic [31:0] IF_NOP           = 32'h0000_0013;
  localparam int          IF_DEPTH_DEFAULT = 2;

endpackage

// File: rtl/if_fifo.sv
// Power-of-two FIFO with synchronous clear and asynchronous active-high reset.
module if_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               din_i,
  input  logic                       pop_i,
  output logic [W-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  // A push into a full FIFO is only taken when a pop frees the slot on the same edge.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues PC requests, queues {pc,instr}, flushes on redirect.
// Optional IF_FETCH_QUEUE_BYPASS_EN forwards a response directly when the queue is empty.
//
// state | meaning
// FETCH | requests issued while queue+inflight has room; responses enqueued
// DRAIN | responses to requests issued before a redirect are dropped
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = IF_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] pc,
  output logic         pc_en,
  input  logic         redirect,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [N-1:0] imem_rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_instr,
  output logic [N-1:0] out_pc
);

  localparam int            CW  = $clog2(DEPTH+1);
  localparam logic [CW-1:0] ONE = CW'(1);

  if_state_e       state_q, state_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   iq_count, tq_count;
  logic [CW:0]     used;
  logic [N-1:0]    tq_head;
  logic [2*N-1:0]  iq_head, head;
  logic            iq_empty, iq_push, iq_pop;
  logic            req_fire, rsp_ok, rsp_keep, bypass;

  assign used     = {1'b0, iq_count} + {1'b0, inflight_q};
  assign iq_empty = (iq_count == '0);

  assign imem_req_addr  = pc;
  assign imem_req_valid = !rst && (state_q == FETCH) && !redirect && (used < (CW+1)'(DEPTH));
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_en          = req_fire;

  // A response with nothing outstanding is illegal and has no effect.
  assign rsp_ok   = imem_rsp_valid && (inflight_q != '0);
  assign rsp_keep = rsp_ok && (state_q == FETCH) && !redirect && (tq_count != '0);

`ifdef IF_FETCH_QUEUE_BYPASS_EN
  assign bypass = rsp_keep && iq_empty && out_ready;
`else
  assign bypass = 1'b0;
`endif

  assign iq_push = rsp_keep && !bypass;
  assign iq_pop  = !iq_empty && out_ready;

  assign head      = bypass ? {tq_head, imem_rsp_data} : iq_head;
  assign out_valid = !iq_empty || bypass;
  assign out_pc    = out_valid ? head[2*N-1:N] : '0;
  assign out_instr = out_valid ? head[N-1:0]   : '0;

  if_fifo #(.W(N), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect),
    .push_i  (req_fire),
    .din_i   (pc),
    .pop_i   (rsp_keep),
    .dout_o  (tq_head),
    .count_o (tq_count)
  );

  if_fifo #(.W(2*N), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (redirect),
    .push_i  (iq_push),
    .din_i   ({tq_head, imem_rsp_data}),
    .pop_i   (iq_pop),
    .dout_o  (iq_head),
    .count_o (iq_count)
  );

  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (req_fire) inflight_d = inflight_d + ONE;
    if (rsp_ok)   inflight_d = inflight_d - ONE;
    if (redirect) begin
      // Everything still outstanding after this edge belongs to the old path.
      discard_d = inflight_d;
      state_d   = (inflight_d != '0) ? DRAIN : FETCH;
    end else if ((state_q == DRAIN) && rsp_ok) begin
      discard_d = discard_q - ONE;
      if (discard_q == ONE) state_d = FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FETCH;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against an epoch-based fetch stream model.
module tb_if_fetch_queue;

  localparam int N     = 32;
  localparam int DEPTH = 2;
`ifdef IF_FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] pc;
  logic         pc_en;
  logic         redirect;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [N-1:0] imem_req_addr;
  logic         imem_rsp_valid;
  logic [N-1:0] imem_rsp_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_instr;
  logic [N-1:0] out_pc;

  always #5 clk = ~clk;

  if_fetch_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_en          (pc_en),
    .redirect       (redirect),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory requests carry the redirect epoch they were issued in; old epochs are stale.
  typedef struct {
    logic [N-1:0] addr;
    int           epoch;
    int           due;
  } pend_t;

  pend_t        pend[$];
  logic [N-1:0] arrived[$];
  logic [N-1:0] pop_log[$];
  logic [N-1:0] acc_log[$];
  int           epoch, outstanding, cyc, last_due, dut_acc;
  logic [N-1:0] pc_nxt, last_target;
  int           k_ready, k_oready, k_redir, k_lat_min, k_lat_max;

  function automatic logic [N-1:0] mem_word(input logic [N-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
  endfunction

  task automatic step();
    bit           rsp_legal, rsp_keep, byp_now, exp_rv, exp_ov;
    int           stale, due;
    logic [N-1:0] hd;
    @(negedge clk);
    cyc++;
    pc             = pc_nxt;
    imem_req_ready = ($urandom_range(0, 99) < k_ready);
    out_ready      = ($urandom_range(0, 99) < k_oready);
    redirect       = ($urandom_range(0, 99) < k_redir);
    rsp_legal      = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        rsp_legal      = 1'b1;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      imem_rsp_valid = 1'b1;
    end
    #1;
    stale = 0;
    foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
    rsp_keep = 1'b0;
    if (rsp_legal) rsp_keep = (pend[0].epoch == epoch) && !redirect;
    byp_now = BYP && rsp_keep && (arrived.size() == 0) && out_ready;
    exp_rv  = (stale == 0) && !redirect && (outstanding < DEPTH);
    exp_ov  = (arrived.size() > 0) || byp_now;

    check_val("req_valid", imem_req_valid, exp_rv);
    check_val("pc_en", pc_en, exp_rv && imem_req_ready);
    check_val("req_addr", imem_req_addr, pc);
    check_val("out_valid", out_valid, exp_ov);
    if (exp_ov) begin
      hd = (arrived.size() > 0) ? arrived[0] : pend[0].addr;
      check_val("out_pc", out_pc, hd);
      check_val("out_instr", out_instr, mem_word(hd));
    end

    if (pc_en) begin
      dut_acc++;
      acc_log.push_back(imem_req_addr);
    end
    if (out_valid && out_ready) pop_log.push_back(out_pc);

    if ((arrived.size() > 0) && out_ready) begin
      void'(arrived.pop_front());
      outstanding--;
    end
    if (rsp_legal) begin
      if (rsp_keep) begin
        if (byp_now) outstanding--;
        else arrived.push_back(pend[0].addr);
      end
      void'(pend.pop_front());
    end
    if (exp_rv && imem_req_ready) begin
      due = cyc + $urandom_range(k_lat_min, k_lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{pc, epoch, due});
      outstanding++;
    end
    if (redirect) begin
      epoch++;
      arrived.delete();
      outstanding = 0;
      pc_nxt      = $urandom & ~32'h3;
      last_target = pc_nxt;
    end else if (pc_en) begin
      pc_nxt = pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    pc             = '0;
    #1;
    check_val("rst_pc_en", pc_en, 1'b0);
    check_val("rst_req_valid", imem_req_valid, 1'b0);
    check_val("rst_out_valid", out_valid, 1'b0);
    check_val("rst_out_instr", out_instr, '0);
    check_val("rst_out_pc", out_pc, '0);
    pend.delete();
    arrived.delete();
    outstanding = 0;
    epoch       = 0;
    last_due    = cyc;
    pc_nxt      = '0;
    repeat (2) @(negedge clk);
    imem_req_ready = 1'b0;
    rst            = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    pc             = '0;
    redirect       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    out_ready      = 1'b0;
    cyc            = 0;
    dut_acc        = 0;
    last_target    = '0;

    // Straight-line fetch with single-cycle memory.
    do_reset();
    k_ready = 100; k_oready = 100; k_redir = 0; k_lat_min = 1; k_lat_max = 1;
    pop_log.delete();
    repeat (8) step();
    check_val("seq_len_ok", pop_log.size() >= 3, 1'b1);
    check_val("seq_pc0", pop_log[0], 32'h0);
    check_val("seq_pc1", pop_log[1], 32'h4);
    check_val("seq_pc2", pop_log[2], 32'h8);

    // Decode stalled: exactly DEPTH requests go out.
    do_reset();
    k_oready = 0; dut_acc = 0;
    repeat (10) step();
    check_val("stall_accepts", dut_acc, DEPTH);

    // Memory not ready for three cycles, then one acceptance.
    do_reset();
    k_oready = 100; k_ready = 0; dut_acc = 0;
    repeat (3) step();
    check_val("hold_accepts", dut_acc, 0);
    k_ready = 100;
    step();
    check_val("rise_accepts", dut_acc, 1);

    // Redirect with two requests in flight at latency 3.
    do_reset();
    k_ready = 100; k_oready = 100; k_lat_min = 3; k_lat_max = 3;
    repeat (2) step();
    k_redir = 100;
    step();
    k_redir = 0;
    acc_log.delete();
    repeat (10) step();
    check_val("redir_first_ok", acc_log.size() > 0, 1'b1);
    check_val("redir_first_addr", acc_log[0], last_target);

    // Randomized phases with varying back-pressure, latency and redirect rates.
    for (int ph = 0; ph < 6; ph++) begin
      k_ready   = 40 + 12 * ph;
      k_oready  = 100 - 15 * ph;
      k_redir   = 2 + 2 * ph;
      k_lat_min = 1;
      k_lat_max = 1 + (ph % 4);
      repeat (350) step();
      if (ph == 2) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
